y_demux4_buf: RTL and testbench

- Buffered 1-to-4 demultiplexer: the distributing counterpart of the 4-to-1 word mux in the datapath library.
- Accepts one SIZE-bit word per cycle with a 2-bit channel select and routes it to one of four output channels.
- Each channel holds one word in a register with its own valid/ready handshake.
- Sits between a single producer (e.g. ALU result or writeback bus) and up to four independent consumers.

---
 rtl/y_demux_pkg.sv | 14 +
 rtl/y_demux_slot.sv | 60 ++++++
 rtl/y_demux4_buf.sv | 70 +++++++
 tb/tb_y_demux4_buf.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/y_demux_pkg.sv
// Shared constants for the buffered 1-to-4 word demultiplexer.
// Channel count, select width, channel indices and default counter width.
package y_demux_pkg;

    localparam int NUM_CH    = 4;
    localparam int SEL_W     = 2;
    localparam int CNT_W_DEF = 16;

    localparam logic [SEL_W-1:0] CH0 = 2'd0;
    localparam logic [SEL_W-1:0] CH1 = 2'd1;
    localparam logic [SEL_W-1:0] CH2 = 2'd2;
    localparam logic [SEL_W-1:0] CH3 = 2'd3;

endpackage

// File: rtl/y_demux_slot.sv
// One demux output channel: single-word register with EMPTY/FULL flag.
// Y_DEMUX_STATS_EN adds a wrapping delivered-word counter.
module y_demux_slot
    import y_demux_pkg::*;
#(
    parameter int SIZE  = 32,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [SIZE-1:0]  d,
    input  logic             ready,
    output logic [SIZE-1:0]  q,
    output logic             valid,
    output logic [CNT_W-1:0] count
);

    localparam logic [0:0] EMPTY = 1'b0;
    localparam logic [0:0] FULL  = 1'b1;

    logic [0:0]      r_state;
    logic [SIZE-1:0] r_q;
    logic            w_deliver;

    assign w_deliver = (r_state == FULL) & ready;

    // A load in the same cycle as a deliver wins, so the slot stays FULL.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= EMPTY;
            r_q     <= '0;
        end else if (load) begin
            r_state <= FULL;
            r_q     <= d;
        end else if (w_deliver) begin
            r_state <= EMPTY;
        end
    end

    assign q     = r_q;
    assign valid = (r_state == FULL);

`ifdef Y_DEMUX_STATS_EN
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_deliver) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign count = r_cnt;
`else
    assign count = '0;
`endif

endmodule

// File: rtl/y_demux4_buf.sv
// Buffered 1-to-4 word demux with per-channel valid/ready handshakes.
// Optional Y_DEMUX_STATS_EN enables per-channel delivered-word counters.
module y_demux4_buf
    import y_demux_pkg::*;
#(
    parameter int SIZE  = 32,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [SIZE-1:0]   in_data,
    input  logic [SEL_W-1:0]  in_sel,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [SIZE-1:0]   z0,
    output logic [SIZE-1:0]   z1,
    output logic [SIZE-1:0]   z2,
    output logic [SIZE-1:0]   z3,
    output logic [NUM_CH-1:0] out_valid,
    input  logic [NUM_CH-1:0] out_ready,
    input  logic [SEL_W-1:0]  stat_sel,
    output logic [CNT_W-1:0]  stat_count
);

    logic [NUM_CH-1:0] w_sel_oh;
    logic [NUM_CH-1:0] w_load;
    logic [SIZE-1:0]   w_q   [NUM_CH];
    logic [CNT_W-1:0]  w_cnt [NUM_CH];
    logic              w_accept;

    always_comb begin
        w_sel_oh = '0;
        case (in_sel)
            CH0:     w_sel_oh = 4'b0001;
            CH1:     w_sel_oh = 4'b0010;
            CH2:     w_sel_oh = 4'b0100;
            CH3:     w_sel_oh = 4'b1000;
            default: w_sel_oh = '0;
        endcase
    end

    assign in_ready = !out_valid[in_sel] | out_ready[in_sel];
    assign w_accept = in_valid & in_ready;
    // Gate with in_valid first so an undriven select while idle stays inert.
    assign w_load   = {NUM_CH{w_accept}} & w_sel_oh;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_slot
        y_demux_slot #(
            .SIZE  (SIZE),
            .CNT_W (CNT_W)
        ) u_slot (
            .clk   (clk),
            .rst   (rst),
            .load  (w_load[g]),
            .d     (in_data),
            .ready (out_ready[g]),
            .q     (w_q[g]),
            .valid (out_valid[g]),
            .count (w_cnt[g])
        );
    end

    assign z0 = w_q[0];
    assign z1 = w_q[1];
    assign z2 = w_q[2];
    assign z3 = w_q[3];

    assign stat_count = w_cnt[stat_sel];

endmodule

// File: tb/tb_y_demux4_buf.sv
// Directed self-checking bench for y_demux4_buf.
// Build with +define+Y_DEMUX_STATS_EN to exercise the counter path.
module tb_y_demux4_buf;

    localparam int SIZE  = 32;
    localparam int CNT_W = 4;

    logic             clk;
    logic             rst;
    logic [SIZE-1:0]  in_data;
    logic [1:0]       in_sel;
    logic             in_valid;
    logic             in_ready;
    logic [SIZE-1:0]  z0, z1, z2, z3;
    logic [3:0]       out_valid;
    logic [3:0]       out_ready;
    logic [1:0]       stat_sel;
    logic [CNT_W-1:0] stat_count;

    logic [SIZE-1:0]  zq [4];

    int n_checks;
    int n_fail;

    y_demux4_buf #(
        .SIZE  (SIZE),
        .CNT_W (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .z0         (z0),
        .z1         (z1),
        .z2         (z2),
        .z3         (z3),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .stat_sel   (stat_sel),
        .stat_count (stat_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        zq[0] = z0;
        zq[1] = z1;
        zq[2] = z2;
        zq[3] = z3;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        n_checks++;
        if (out_valid !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_valid got=%b exp=0000", out_valid);
        end
        n_checks++;
        if (stat_count !== '0) begin
            n_fail++;
            $display("FAIL reset_stat got=%0d exp=0", stat_count);
        end
        rst = 1'b0;
        step();
        out_ready = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1;
            in_sel   = 2'(k);
            in_data  = 32'hC0 + 32'(k);
            step();
        end
        in_valid = 1'b0;
        in_sel   = 2'd0;
        #1;
        n_checks++;
        if (out_valid !== 4'b1111) begin
            n_fail++;
            $display("FAIL preload_valid got=%b exp=1111", out_valid);
        end
        n_checks++;
        if (z3 !== 32'hC3) begin
            n_fail++;
            $display("FAIL preload_z3 got=%h exp=000000c3", z3);
        end
        #1 rst = 1'b1;
        #1;
        n_checks++;
        if (out_valid !== 4'b0000) begin
            n_fail++;
            $display("FAIL async_rst_valid got=%b exp=0000", out_valid);
        end
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (zq[k] !== '0) begin
                n_fail++;
                $display("FAIL async_rst_z%0d got=%h exp=0", k, zq[k]);
            end
        end
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL async_rst_ready got=%b exp=1", in_ready);
        end
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_routing();
        logic [SIZE-1:0] exp_z [4];
        logic [3:0]      exp_v;
        logic [1:0]      s;
        logic [SIZE-1:0] d;
        out_ready = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1;
            in_sel   = 2'(k);
            in_data  = 32'hA0 + 32'(k);
            step();
            n_checks++;
            if (zq[k] !== 32'hA0 + 32'(k) || out_valid !== 4'(1 << k)) begin
                n_fail++;
                $display("FAIL route_ch%0d z=%h v=%b exp z=%h v=%b",
                         k, zq[k], out_valid, 32'hA0 + 32'(k), 4'(1 << k));
            end
        end
        in_valid = 1'b0;
        step();
        n_checks++;
        if (out_valid !== 4'b0000) begin
            n_fail++;
            $display("FAIL route_drain got=%b exp=0000", out_valid);
        end
        for (int k = 0; k < 4; k++) exp_z[k] = zq[k] === 'x ? '0 : 32'hA0 + 32'(k);
        for (int i = 0; i < 10; i++) begin
            s = 2'($urandom_range(0, 3));
            d = $urandom;
            in_valid = 1'b1;
            in_sel   = s;
            in_data  = d;
            step();
            exp_z[s] = d;
            exp_v    = 4'(1 << s);
            n_checks++;
            if (out_valid !== exp_v || zq[s] !== exp_z[s]) begin
                n_fail++;
                $display("FAIL route_rand%0d z=%h v=%b exp z=%h v=%b",
                         i, zq[s], out_valid, exp_z[s], exp_v);
            end
        end
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_backpressure();
        out_ready = 4'b1011;
        in_valid  = 1'b1;
        in_sel    = 2'd2;
        in_data   = 32'h1234;
        step();
        n_checks++;
        if (z2 !== 32'h1234 || out_valid[2] !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_first z2=%h v2=%b exp 1234/1", z2, out_valid[2]);
        end
        in_data = 32'h5678;
        #1;
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_stall_ready got=%b exp=0", in_ready);
        end
        step();
        n_checks++;
        if (z2 !== 32'h1234 || out_valid[2] !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_hold z2=%h v2=%b exp 1234/1", z2, out_valid[2]);
        end
        in_sel  = 2'd1;
        in_data = 32'h55;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_other_ready got=%b exp=1", in_ready);
        end
        step();
        n_checks++;
        if (z1 !== 32'h55 || out_valid[1] !== 1'b1 || z2 !== 32'h1234) begin
            n_fail++;
            $display("FAIL bp_other z1=%h v1=%b z2=%h exp 55/1/1234",
                     z1, out_valid[1], z2);
        end
        in_sel  = 2'd2;
        in_data = 32'h5678;
        step();
        n_checks++;
        if (z2 !== 32'h1234 || out_valid[2] !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_hold2 z2=%h v2=%b exp 1234/1", z2, out_valid[2]);
        end
        out_ready = 4'b1111;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_release_ready got=%b exp=1", in_ready);
        end
        step();
        n_checks++;
        if (z2 !== 32'h5678 || out_valid[2] !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_release z2=%h v2=%b exp 5678/1", z2, out_valid[2]);
        end
        in_valid = 1'b0;
        step();
        n_checks++;
        if (out_valid !== 4'b0000) begin
            n_fail++;
            $display("FAIL bp_drain got=%b exp=0000", out_valid);
        end
    endtask

    task automatic test_passthrough();
        out_ready = 4'b1111;
        in_sel    = 2'd3;
        in_valid  = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_data = 32'(i);
            #1;
            n_checks++;
            if (in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL pass_ready%0d got=%b exp=1", i, in_ready);
            end
            step();
            n_checks++;
            if (z3 !== 32'(i) || out_valid[3] !== 1'b1) begin
                n_fail++;
                $display("FAIL pass_z3_%0d z3=%h v3=%b exp %h/1",
                         i, z3, out_valid[3], 32'(i));
            end
        end
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_idle();
        out_ready = 4'b0000;
        in_valid  = 1'b1;
        in_sel    = 2'd0;
        in_data   = 32'h77;
        step();
        in_valid = 1'b0;
        in_sel   = 2'bxx;
        in_data  = 'x;
        step();
        step();
        step();
        n_checks++;
        if (out_valid !== 4'b0001 || z0 !== 32'h77) begin
            n_fail++;
            $display("FAIL idle_state v=%b z0=%h exp 0001/77", out_valid, z0);
        end
        n_checks++;
        if (^{z0, z1, z2, z3, out_valid} === 1'bx) begin
            n_fail++;
            $display("FAIL idle_x v=%b z0=%h z1=%h z2=%h z3=%h",
                     out_valid, z0, z1, z2, z3);
        end
        in_sel    = 2'd0;
        in_data   = '0;
        out_ready = 4'b1111;
        step();
    endtask

    task automatic test_stats();
        logic [CNT_W-1:0] exp0;
`ifdef Y_DEMUX_STATS_EN
        exp0 = 4'd1;
`else
        exp0 = 4'd0;
`endif
        #1 rst = 1'b1;
        #1 rst = 1'b0;
        step();
        out_ready = 4'b1111;
        stat_sel  = 2'd0;
        in_sel    = 2'd0;
        in_valid  = 1'b1;
        for (int i = 0; i < 17; i++) begin
            in_data = 32'(i);
            step();
        end
        in_valid = 1'b0;
        step();
        n_checks++;
        if (stat_count !== exp0) begin
            n_fail++;
            $display("FAIL stat_ch0 got=%0d exp=%0d", stat_count, exp0);
        end
        stat_sel = 2'd1;
        #1;
        n_checks++;
        if (stat_count !== '0) begin
            n_fail++;
            $display("FAIL stat_ch1 got=%0d exp=0", stat_count);
        end
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst       = 1'b1;
        in_data   = '0;
        in_sel    = 2'd0;
        in_valid  = 1'b0;
        out_ready = 4'b0000;
        stat_sel  = 2'd0;
        test_reset();
        test_routing();
        test_backpressure();
        test_passthrough();
        test_idle();
        test_stats();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
